// File: rtl/activation_threshold_scheduler_if.sv
// Bundle of config, popcount-in and activation-out signals for activation_threshold_scheduler.
// master = producer/consumer side (bench or neighbours), slave = scheduler side.
interface activation_threshold_scheduler_if #(
  parameter int SUM_WIDTH   = 4,
  parameter int NUM_NEURONS = 8
);
  localparam int IDX_WIDTH = $clog2(NUM_NEURONS);

  logic                   cfg_we;
  logic [IDX_WIDTH-1:0]   cfg_addr;
  logic [SUM_WIDTH-1:0]   cfg_data;
  logic                   cfg_err;

  // Handshake: a transfer happens on a rising clk edge where valid && ready are both 1;
  // the source holds data stable while valid is 1 and ready is 0.
  logic                   in_valid;
  logic                   in_ready;
  logic [SUM_WIDTH-1:0]   in_popcount;

  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_NEURONS-1:0] out_act;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_popcount, out_ready,
    input  cfg_err, in_ready, out_valid, out_act
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_popcount, out_ready,
    output cfg_err, in_ready, out_valid, out_act
  );
endinterface

// File: rtl/activation_threshold_scheduler.sv
// Thresholds NUM_NEURONS popcount beats into one activation vector, one vector per EMIT.
// Optional ACT_COUNT_EN adds out_count, the number of fired neurons in out_act.
module activation_threshold_scheduler #(
  parameter int SUM_WIDTH         = 4,
  parameter int NUM_NEURONS       = 8,
  parameter int DEFAULT_THRESHOLD = 5
) (
  input  logic                              clk,
  input  logic                              reset_n,
  activation_threshold_scheduler_if.slave   bus,
  output logic                              busy,
  output logic                              dbg_state
`ifdef ACT_COUNT_EN
  ,
  output logic [$clog2(NUM_NEURONS+1)-1:0]  out_count
`endif
);
  localparam int IDX_WIDTH = $clog2(NUM_NEURONS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(NUM_NEURONS - 1);
  localparam logic [IDX_WIDTH:0]   ADDR_LIMIT = (IDX_WIDTH + 1)'(NUM_NEURONS);
  localparam logic [SUM_WIDTH-1:0] THR_RESET  = SUM_WIDTH'(DEFAULT_THRESHOLD);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } state_t;

  state_t                 state;
  logic [IDX_WIDTH-1:0]   idx;
  logic [NUM_NEURONS-1:0] act;
  logic [NUM_NEURONS-1:0] act_next;
  logic [SUM_WIDTH-1:0]   thr [NUM_NEURONS];
  logic                   cfg_err_q;
  logic                   beat_fire;
  logic                   cfg_ok;
  logic                   fires;

  assign bus.in_ready  = (state == ST_COLLECT);
  assign bus.out_valid = (state == ST_EMIT);
  assign bus.out_act   = act;
  assign bus.cfg_err   = cfg_err_q;
  assign busy          = (state == ST_EMIT) || (idx != '0);
  assign dbg_state     = state;

  assign beat_fire = bus.in_valid && (state == ST_COLLECT);
  // Thresholds may only change between vectors so every neuron of a vector sees one table.
  assign cfg_ok    = (state == ST_COLLECT) && (idx == '0) &&
                     ({1'b0, bus.cfg_addr} < ADDR_LIMIT);
  assign fires     = (bus.in_popcount >= thr[idx]);

  always_comb begin
    act_next = act;
    if (beat_fire) begin
      act_next[idx] = fires;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_COLLECT;
      idx       <= '0;
      act       <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        thr[i] <= THR_RESET;
      end
    end else begin
      cfg_err_q <= bus.cfg_we && !cfg_ok;
      // Nonblocking write: a same-cycle neuron-0 compare still reads the old threshold.
      if (bus.cfg_we && cfg_ok) begin
        thr[bus.cfg_addr] <= bus.cfg_data;
      end
      case (state)
        ST_COLLECT: begin
          if (beat_fire) begin
            act <= act_next;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= ST_EMIT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (bus.out_ready) begin
            state <= ST_COLLECT;
            act   <= '0;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

`ifdef ACT_COUNT_EN
  // Tracks the running count so it is already final in the first EMIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_count <= '0;
    end else if (beat_fire) begin
      out_count <= ($clog2(NUM_NEURONS+1))'($countones(act_next));
    end
  end
`endif

endmodule

// File: tb/tb_activation_threshold_scheduler.sv
// Directed plus randomized bench for activation_threshold_scheduler with a threshold-table model.
module tb_activation_threshold_scheduler;
  localparam int SW  = 4;
  localparam int NN  = 8;
  localparam int NN6 = 6;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  activation_threshold_scheduler_if #(.SUM_WIDTH(SW), .NUM_NEURONS(NN))  bus ();
  activation_threshold_scheduler_if #(.SUM_WIDTH(SW), .NUM_NEURONS(NN6)) bus6 ();

  logic busy, dbg_state, busy6, dbg_state6;
`ifdef ACT_COUNT_EN
  logic [$clog2(NN+1)-1:0]  out_count;
  logic [$clog2(NN6+1)-1:0] out_count6;
`endif

  activation_threshold_scheduler #(.SUM_WIDTH(SW), .NUM_NEURONS(NN), .DEFAULT_THRESHOLD(5)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef ACT_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  activation_threshold_scheduler #(.SUM_WIDTH(SW), .NUM_NEURONS(NN6), .DEFAULT_THRESHOLD(5)) u_dut6 (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus6.slave),
    .busy      (busy6),
    .dbg_state (dbg_state6)
`ifdef ACT_COUNT_EN
    ,
    .out_count (out_count6)
`endif
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  int thr_m [NN];
  logic [SW-1:0] cur_pops [NN];
  int beats_in_vec = 0;
  logic [NN-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NN-1:0] model_act(input logic [SW-1:0] p [NN]);
    logic [NN-1:0] r;
    for (int i = 0; i < NN; i++) r[i] = (int'(p[i]) >= thr_m[i]);
    return r;
  endfunction

  function automatic int count_ones(input logic [NN-1:0] v);
    int n = 0;
    for (int i = 0; i < NN; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NN; i++) thr_m[i] = 5;
    beats_in_vec = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [SW-1:0] pop);
    int n = 0;
    bus.in_valid    = 1'b1;
    bus.in_popcount = pop;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("beat_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    cur_pops[beats_in_vec] = pop;
    beats_in_vec++;
    check("busy_after_beat", 32'(busy), 32'd1);
    if (beats_in_vec == NN) begin
      exp_q.push_back(model_act(cur_pops));
      beats_in_vec = 0;
      check("latency_out_valid", 32'(bus.out_valid), 32'd1);
    end
  endtask

  task automatic send_vector(input logic [SW-1:0] p [NN], input bit gaps);
    for (int i = 0; i < NN; i++) begin
      if (gaps) begin
        int g = 0;
        while ($urandom_range(0, 1) == 1 && g < 8) begin
          tick();
          g++;
        end
      end
      send_beat(p[i]);
    end
  endtask

  task automatic recv_vector(input int hold);
    int n = 0;
    logic [NN-1:0] exp;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    check("out_valid_wait", 32'(bus.out_valid), 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check("out_act", 32'(bus.out_act), 32'(exp));
`ifdef ACT_COUNT_EN
    check("out_count", 32'(out_count), 32'(count_ones(exp)));
`endif
    for (int c = 0; c < hold; c++) begin
      bus.in_valid    = 1'b1;
      bus.in_popcount = SW'($urandom_range(0, 15));
      tick();
      check("hold_out_act", 32'(bus.out_act), 32'(exp));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("cleared_act", 32'(bus.out_act), 32'd0);
  endtask

  task automatic cfg_write(input int addr, input int data);
    bit exp_err;
    exp_err = (beats_in_vec != 0) || (exp_q.size() != 0) || (addr >= NN);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'(addr);
    bus.cfg_data = SW'(data);
    tick();
    bus.cfg_we = 1'b0;
    check("cfg_err", 32'(bus.cfg_err), 32'(exp_err));
    if (!exp_err) thr_m[addr] = data;
    tick();
    check("cfg_err_pulse_end", 32'(bus.cfg_err), 32'd0);
  endtask

  task automatic cfg6_write(input int addr, input int data);
    bus6.cfg_we   = 1'b1;
    bus6.cfg_addr = 3'(addr);
    bus6.cfg_data = SW'(data);
    tick();
    bus6.cfg_we = 1'b0;
    check("cfg6_err", 32'(bus6.cfg_err), 32'(addr >= NN6));
    tick();
    check("cfg6_err_pulse_end", 32'(bus6.cfg_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [SW-1:0] v [NN];
    logic [SW-1:0] t1 [NN];
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
    bus.in_valid = 0; bus.in_popcount = 0; bus.out_ready = 0;
    bus6.cfg_we = 0; bus6.cfg_addr = 0; bus6.cfg_data = 0;
    bus6.in_valid = 0; bus6.in_popcount = 0; bus6.out_ready = 0;
    model_reset();
    t1 = '{4'd5, 4'd4, 4'd15, 4'd0, 4'd6, 4'd5, 4'd1, 4'd9};

    // reset state
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_act", 32'(bus.out_act), 32'd0);
    check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
`ifdef ACT_COUNT_EN
    check("rst_out_count", 32'(out_count), 32'd0);
`endif
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // default thresholds, back-to-back beats
    send_vector(t1, 1'b0);
    check("t1_literal", 32'(bus.out_act), 32'hB5);
    recv_vector(0);

    // idle write thr[3]=0, all-zero beats
    cfg_write(3, 0);
    for (int i = 0; i < NN; i++) v[i] = '0;
    send_vector(v, 1'b0);
    check("t2_literal", 32'(bus.out_act), 32'h08);
    recv_vector(0);

    // write mid-vector rejected; thr[0] keeps 5
    send_beat(4'd7);
    send_beat(4'd2);
    cfg_write(0, 0);
    for (int i = 2; i < NN; i++) send_beat(SW'($urandom_range(0, 15)));
    recv_vector(0);
    send_vector(v, 1'b0);
    recv_vector(0);
    // write while EMIT pending also rejected
    send_vector(t1, 1'b0);
    cfg_write(1, 0);
    recv_vector(0);
    // 6-neuron instance: address range boundary
    cfg6_write(7, 3);
    cfg6_write(6, 3);
    cfg6_write(5, 3);

    // long backpressure with spurious in_valid
    for (int i = 0; i < NN; i++) v[i] = SW'($urandom_range(0, 15));
    send_vector(v, 1'b0);
    recv_vector(10);
    send_vector(t1, 1'b0);
    recv_vector(0);

    // async reset mid-vector at idx=4
    cfg_write(3, 15);
    for (int i = 0; i < 4; i++) send_beat(SW'($urandom_range(0, 15)));
    #2 reset_n = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_in_ready", 32'(bus.in_ready), 32'd1);
    model_reset();
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < NN; i++) v[i] = 4'd5;
    send_vector(v, 1'b0);
    check("post_reset_thr", 32'(bus.out_act), 32'hFF);
    // async reset while EMIT is pending
    #2 reset_n = 1'b0;
    #1;
    check("async_emit_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_emit_busy", 32'(busy), 32'd0);
    model_reset();
    tick();
    reset_n = 1'b1;
    tick();

    // random gaps with the first vector's data
    send_vector(t1, 1'b1);
    check("t6_literal", 32'(bus.out_act), 32'hB5);
    recv_vector($urandom_range(0, 2));

    // randomized thresholds, data, gaps and backpressure
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 1) == 1) cfg_write($urandom_range(0, NN - 1), $urandom_range(0, 15));
      for (int i = 0; i < NN; i++) begin
        case ($urandom_range(0, 3))
          0: v[i] = '0;
          1: v[i] = '1;
          default: v[i] = SW'($urandom_range(0, 15));
        endcase
      end
      send_vector(v, 1'b1);
      if ($urandom_range(0, 3) == 0) cfg_write($urandom_range(0, NN - 1), 0);
      recv_vector($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
